// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// the NOP encoding, jump opcodes and the decoder's Jump control codes.
`timescale 1ns/1ps
package instr_fetch_pkg;

    typedef enum logic [0:0] {
        ST_FETCH    = 1'b0,
        ST_BUFFERED = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;

    localparam logic [1:0] JUMPC_NONE = 2'b00;
    localparam logic [1:0] JUMPC_JAL  = 2'b01;
    localparam logic [1:0] JUMPC_JR   = 2'b10;
    localparam logic [1:0] JUMPC_J    = 2'b11;

    // Decoder Jump codes that request a J/JAL-style redirect.
    function automatic logic is_jump_code(input logic [1:0] code);
        return (code == JUMPC_J) || (code == JUMPC_JAL);
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
`timescale 1ns/1ps
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_fetch_pc_next_sel.sv
// Redirect arbitration (jr > jump > branch) and word-aligned target formation.
`timescale 1ns/1ps
module pc_next_sel
    import instr_fetch_pkg::*;
(
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] if_id_pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    // Only the region bits of the sequential PC feed the jump target.
    logic unused_pc4_bits;
    assign unused_pc4_bits = ^if_id_pc_plus4[27:0];

    always_comb begin
        redirect_o = jr | jump | branch_taken;
        target_o   = 32'h0000_0000;
        if (jr) begin
            target_o = word_align(jr_target);
        end else if (jump) begin
            target_o = {if_id_pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            target_o = word_align(branch_target);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, one-entry skid buffer for stalls
// and the IF/ID pipeline register, with jr/jump/branch redirects.
`timescale 1ns/1ps
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    input  logic                  jump,
    input  logic [25:0]           jump_index,
    input  logic                  jr,
    input  logic [31:0]           jr_target,
    instr_fetch_if.master         imem,
    output logic                  if_id_valid,
    output logic [31:0]           if_id_instr,
    output logic [31:0]           if_id_pc_plus4,
    output logic [5:0]            opcode
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;

    logic [31:0]  pc_plus4;
    logic         redirect;
    logic [31:0]  redirect_target;
    logic         advance;
    logic         skid;
    logic [31:0]  issue_word;

    assign pc_plus4 = pc_q + 32'd4;

    pc_next_sel u_pc_next_sel (
        .jr             (jr),
        .jr_target      (jr_target),
        .jump           (jump),
        .jump_index     (jump_index),
        .if_id_pc_plus4 (pc4_q),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .redirect_o     (redirect),
        .target_o       (redirect_target)
    );

    // An instruction enters IF/ID either straight from memory or from the skid buffer.
    assign advance    = !stall && ((state_q == ST_FETCH && imem.imem_ready) ||
                                   (state_q == ST_BUFFERED));
    assign skid       = stall && (state_q == ST_FETCH) && imem.imem_ready;
    assign issue_word = (state_q == ST_BUFFERED) ? buf_q : imem.imem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH:    if (skid)   state_d = ST_BUFFERED;
                ST_BUFFERED: if (!stall) state_d = ST_FETCH;
                default:                 state_d = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        imem.imem_req  = !reset && (state_q == ST_FETCH);
        imem.imem_addr = pc_q;
        if_id_valid    = valid_q;
        if_id_instr    = instr_q;
        if_id_pc_plus4 = pc4_q;
        opcode         = instr_q[31:26];
    end

    // A redirect squashes whatever memory returns this cycle and any buffered word.
    always_comb begin
        pc_d    = pc_q;
        buf_d   = buf_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (redirect) begin
            pc_d    = redirect_target;
            buf_d   = NOP_INSTR;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (advance) begin
            pc_d    = pc_plus4;
            valid_d = 1'b1;
            instr_d = issue_word;
            pc4_d   = pc_plus4;
        end else if (skid) begin
            buf_d   = imem.imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= word_align(RESET_PC);
            buf_q   <= NOP_INSTR;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, wait states, stall/skid,
// redirect priority, PC wrap and reset during a stall.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic [5:0]  opcode;

    int checks = 0;
    int errors = 0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_index     (jump_index),
        .jr             (jr),
        .jr_target      (jr_target),
        .imem           (bus),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .opcode         (opcode)
    );

    always #5 clk = ~clk;

    // Memory image: each word is its own address with a recognisable opcode mixed in.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0;
        bus.imem_ready = 1'b1;
        step(); step();
        check("rst_req",   {31'b0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'b0, if_id_valid},  32'd0);
        check("rst_instr", if_id_instr,           32'h0);
        check("rst_pc4",   if_id_pc_plus4,        32'h0);
        check("rst_addr",  bus.imem_addr,         32'h0);

        // Zero-wait streaming from RESET_PC.
        reset = 1'b0;
        #1;
        check("first_req",  {31'b0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr,         32'h0);
        step();
        check("seq0_pc4",   if_id_pc_plus4, 32'h4);
        check("seq0_instr", if_id_instr,    32'h8C00_0000);
        check("seq0_valid", {31'b0, if_id_valid}, 32'd1);
        check("seq0_op",    {26'b0, opcode}, 32'h23);
        check("seq0_addr",  bus.imem_addr,  32'h4);
        step();
        check("seq1_pc4",   if_id_pc_plus4, 32'h8);
        check("seq1_addr",  bus.imem_addr,  32'h8);
        step();
        check("seq2_pc4",   if_id_pc_plus4, 32'hC);
        check("seq2_addr",  bus.imem_addr,  32'hC);
        step();
        check("seq3_addr",  bus.imem_addr,  32'h10);

        // Three wait states at 0x10.
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_addr",  bus.imem_addr,         32'h10);
            check("wait_pc4",   if_id_pc_plus4,        32'h10);
            check("wait_valid", {31'b0, if_id_valid},  32'd1);
        end
        bus.imem_ready = 1'b1;
        step();
        check("wait_done_pc4",   if_id_pc_plus4, 32'h14);
        check("wait_done_instr", if_id_instr,    32'h8C00_0010);
        check("wait_done_addr",  bus.imem_addr,  32'h14);
        step(); step(); step();
        check("pre_stall_addr", bus.imem_addr, 32'h20);

        // Stall when the word at 0x20 returns: held in the skid buffer.
        stall = 1'b1;
        step();
        check("buf_req",  {31'b0, bus.imem_req}, 32'd0);
        check("buf_addr", bus.imem_addr,         32'h20);
        check("buf_pc4",  if_id_pc_plus4,        32'h20);
        step();
        check("buf_hold_req", {31'b0, bus.imem_req}, 32'd0);
        check("buf_hold_pc4", if_id_pc_plus4,        32'h20);
        stall = 1'b0;
        step();
        check("unbuf_pc4",   if_id_pc_plus4,        32'h24);
        check("unbuf_instr", if_id_instr,           32'h8C00_0020);
        check("unbuf_addr",  bus.imem_addr,         32'h24);
        check("unbuf_req",   {31'b0, bus.imem_req}, 32'd1);

        // Branch into the 0x1000_0000 region, then a jump relative to pc_plus4.
        branch_taken = 1'b1; branch_target = 32'h1000_0006;
        step();
        check("br_addr",  bus.imem_addr,        32'h1000_0004);
        check("br_valid", {31'b0, if_id_valid}, 32'd0);
        check("br_instr", if_id_instr,          32'h0);
        branch_taken = 1'b0;
        step();
        check("br_fetch_pc4", if_id_pc_plus4, 32'h1000_0008);
        jump = 1'b1; jump_index = 26'h000_0040;
        step();
        check("jmp_addr",  bus.imem_addr,        32'h1000_0100);
        check("jmp_valid", {31'b0, if_id_valid}, 32'd0);
        check("jmp_instr", if_id_instr,          32'h0);
        check("jmp_op",    {26'b0, opcode},      32'h0);

        // All three redirects at once: jr wins.
        jr = 1'b1; jr_target = 32'h0000_2003; branch_taken = 1'b1; branch_target = 32'h3000;
        step();
        check("prio_addr", bus.imem_addr, 32'h2000);
        jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        step();
        check("prio_fetch_pc4", if_id_pc_plus4, 32'h2004);

        // Redirect while stalled in BUFFERED discards the buffered word.
        stall = 1'b1;
        step();
        check("buf2_req", {31'b0, bus.imem_req}, 32'd0);
        branch_taken = 1'b1; branch_target = 32'h4000;
        step();
        check("redir_buf_addr",  bus.imem_addr,         32'h4000);
        check("redir_buf_req",   {31'b0, bus.imem_req}, 32'd1);
        check("redir_buf_instr", if_id_instr,           32'h0);
        check("redir_buf_valid", {31'b0, if_id_valid},  32'd0);
        branch_taken = 1'b0; stall = 1'b0;
        step();
        check("post_redir_instr", if_id_instr,    32'h8C00_4000);
        check("post_redir_pc4",   if_id_pc_plus4, 32'h4004);

        // PC wrap at the top of the address space.
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        check("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        step();
        check("wrap_addr",  bus.imem_addr,  32'h0);
        check("wrap_pc4",   if_id_pc_plus4, 32'h0);
        check("wrap_instr", if_id_instr,    32'h73FF_FFFC);
        step();
        check("wrap2_addr", bus.imem_addr,  32'h4);

        // Reset asserted mid-stall, alongside a redirect.
        stall = 1'b1;
        step();
        check("pre_rst_req", {31'b0, bus.imem_req}, 32'd0);
        reset = 1'b1; jr = 1'b1; jr_target = 32'h5000;
        step();
        check("mid_rst_req",   {31'b0, bus.imem_req}, 32'd0);
        check("mid_rst_valid", {31'b0, if_id_valid},  32'd0);
        check("mid_rst_instr", if_id_instr,           32'h0);
        check("mid_rst_pc4",   if_id_pc_plus4,        32'h0);
        check("mid_rst_addr",  bus.imem_addr,         32'h0);
        reset = 1'b0; jr = 1'b0; stall = 1'b0;
        #1;
        check("rel_req",  {31'b0, bus.imem_req}, 32'd1);
        check("rel_addr", bus.imem_addr,         32'h0);
        step();
        check("rel_pc4",   if_id_pc_plus4,       32'h4);
        check("rel_valid", {31'b0, if_id_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hazard hold; freezes PC and IF/ID register.
REQ-005 branch_taken  input  1  taken conditional branch resolved downstream.
REQ-006 branch_target  input  32  branch destination byte address.
REQ-007 jump  input  1  J/JAL redirect (decoder Jump code 2'b11 or 2'b01).
REQ-008 jump_index  input  26  instr[25:0] of the jump.
REQ-009 jr  input  1  register-jump redirect.
REQ-010 jr_target  input  32  register value for jr.
REQ-011 imem_req  output  1  fetch request to instruction memory.
REQ-012 imem_addr  output  32  word-aligned fetch address (current PC).
REQ-013 imem_rdata  input  32  instruction word; valid when imem_ready=1.
REQ-014 imem_ready  input  1  memory completes request this cycle.
REQ-015 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-016 if_id_instr  output  32  fetched instruction.
REQ-017 if_id_pc_plus4  output  32  address of fetched instruction + 4.
REQ-018 opcode  output  6  if_id_instr[31:26], feeds the decoder's opcode input.

Function
REQ-019 States: FETCH (imem_req=1), BUFFERED (instruction held in one-entry skid buffer, imem_req=0).
REQ-020 imem_addr = PC at all times; PC[1:0] always 2'b00.
REQ-021 FETCH, imem_ready=1, stall=0: IF/ID <= {1, imem_rdata, PC+4}; PC <= PC+4; stay FETCH.
REQ-022 FETCH, imem_ready=1, stall=1: skid buffer <= imem_rdata; PC unchanged; IF/ID unchanged; go BUFFERED.
REQ-023 FETCH, imem_ready=0: PC, IF/ID unchanged; imem_addr held stable until ready.
REQ-024 BUFFERED, stall=0: IF/ID <= {1, buffer, PC+4}; PC <= PC+4; go FETCH. BUFFERED, stall=1: hold.
REQ-025 Redirect = jr | jump | branch_taken; priority jr > jump > branch_taken.
REQ-026 Targets: jr -> {jr_target[31:2],2'b00}; jump -> {if_id_pc_plus4[31:28], jump_index, 2'b00}; branch -> {branch_target[31:2],2'b00}.
REQ-027 Redirect in any state: PC <= target; if_id_valid <= 0, if_id_instr <= 32'h0 (NOP); buffer discarded; next state FETCH.
REQ-028 Redirect overrides stall and any imem_ready in the same cycle; the returned word is dropped.
REQ-029 Memory tolerates address change while imem_ready=0; no outstanding request survives a redirect.
REQ-030 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-031 Latency: instruction at PC appears on IF/ID the edge imem_ready=1 is sampled (zero-wait memory: 1 instruction/cycle).

Reset
REQ-032 While reset=1: PC=RESET_PC, state=FETCH, imem_req=0, if_id_valid=0, if_id_instr=0, if_id_pc_plus4=0, buffer cleared.
REQ-033 Reset dominates stall, redirect and imem_ready; first request (imem_addr=RESET_PC) issues the cycle after reset falls.

Structure
REQ-034 Shared package holds: state enum, NOP constant 32'h0, opcode constants (J=6'd2, JAL=6'd3), Jump code constants.
REQ-035 One sub-module pc_next_sel: combinational redirect priority and target formation (REQ-025/026).

Verification
REQ-036 Reset release, RESET_PC=0, imem_ready=1 constantly -> imem_addr 0,4,8,... ; if_id_pc_plus4 4,8,12 on successive cycles.
REQ-037 imem_ready low 3 cycles at PC=0x10 -> imem_addr stays 0x10, if_id_valid unchanged, then instruction captured with pc_plus4=0x14.
REQ-038 stall=1 when word at 0x20 returns -> BUFFERED, imem_req=0; stall drops -> IF/ID gets word, pc_plus4=0x24, next addr 0x24.
REQ-039 jump=1, jump_index=26'h000_0040, if_id_pc_plus4=0x1000_0008 -> PC=0x1000_0100, if_id_valid=0; jr and branch_taken same cycle -> jr_target wins.
REQ-040 Redirect with stall=1 in BUFFERED -> buffer dropped, PC=target, state FETCH, if_id_instr=0.
REQ-041 PC=0xFFFF_FFFC fetch -> next imem_addr 0x0000_0000; reset mid-stall -> all outputs per REQ-032 next cycle.
